ppnx_xfer_ctl: RTL
==================

Name: ppnx_xfer_ctl

Overview:
- Sequencer and two-port arbiter for the PPN<->IDB transceiver pair (upper 10B, lower 9B) on the CPU/MMU board.
- Generates EIPU_n, EIPL_n, EIPUR_n and ESTOF_n so that a microcode requester and a maintenance requester can read PPN onto IDB, or write IDB into PPN, without bus fights.
- Guarantees that direction (ESTOF_n) changes only while both transceiver enables are deasserted, with an enforced turnaround gap.

Parameters:
- HOLD_CYC, 2, cycles the enables stay asserted per transfer (legal range 1..15).
- TURN_CYC, 1, idle cycles inserted before a transfer whose direction differs from the current ESTOF_n (legal range 1..3).

Ports:
- sysclk  in  1  system clock, rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- uc_req  in  1  microcode request, level; held until uc_ack.
- uc_wr  in  1  1 = IDB->PPN (write), 0 = PPN->IDB (read).
- uc_mode  in  2  00 full 16 bit, 01 upper only, 10 lower only, 11 upper-restricted (bit 8 only).
- uc_ack  out  1  one-cycle completion pulse.
- mnt_req, mnt_wr, mnt_mode, mnt_ack  same as the uc_ ports, for the maintenance requester.
- EIPU_n  out  1  upper transceiver enable, active low.
- EIPL_n  out  1  lower transceiver enable, active low.
- EIPUR_n  out  1  upper-restricted select, active low.
- ESTOF_n  out  1  direction: 1 = PPN->IDB, 0 = IDB->PPN.
- busy  out  1  high from grant through the DONE cycle.
- gnt_mnt  out  1  current or last grant owner: 0 = uc, 1 = mnt.

Behaviour:
- Clock and reset: one clock, sysclk. Reset is asynchronous and active-low on sys_rst_n.
- Reset values: EIPU_n = EIPL_n = EIPUR_n = 1, ESTOF_n = 1, uc_ack = mnt_ack = 0, busy = 0, gnt_mnt = 1, so uc wins the first contention. FSM resets to IDLE and all counters to 0.
- All outputs are registered.
- FSM states are IDLE, TURN, ACTIVE, DONE.
- IDLE:
  - If any request is present, grant it. With both present, round-robin: grant the requester that is not gnt_mnt.
  - On grant, latch wr/mode, set gnt_mnt and set busy.
  - If the latched wr disagrees with the current ESTOF_n (wr = 1 needs ESTOF_n = 0), go to TURN; otherwise go to ACTIVE.
- TURN:
  - Enables stay deasserted.
  - ESTOF_n takes its new value on TURN entry.
  - Remain TURN_CYC cycles, then go to ACTIVE.
- ACTIVE:
  - Assert enables per latched mode for exactly HOLD_CYC cycles:
    - 00: EIPU_n = 0, EIPL_n = 0.
    - 01: EIPU_n = 0 only.
    - 10: EIPL_n = 0 only.
    - 11: EIPU_n = 0 and EIPUR_n = 0.
  - Then go to DONE.
- DONE:
  - Deassert all enables and pulse the owner's ack for one cycle.
  - busy is still 1 in DONE and drops on return to IDLE.
  - ESTOF_n holds its value (no change back to 1).
- Latency, same direction: request seen at edge N, enables low over cycles N+1..N+HOLD_CYC, ack at N+HOLD_CYC+1.
- Latency, direction change: add TURN_CYC.
- Minimum request-to-request spacing is one IDLE cycle. Back-to-back grants are allowed from IDLE only.
- Request dropped mid-transfer: the transfer still completes and ack is still issued. wr/mode changes after grant are ignored.
- A requester must drop req in the cycle after its ack. If req is still high, it is treated as a new request.
- Mode 11 combined with wr = 0 is legal: the upper IDB byte carries the restricted value.
- Invariant: EIPU_n and EIPL_n are never 0 in the same cycle in which ESTOF_n changes.
- Invariant: EIPUR_n = 0 implies EIPU_n = 0.
- Reset mid-operation: asynchronous return to the reset values. No ack is issued for the aborted transfer.

Optional Feature:
- Macro: PPNX_XFER_STATS_EN.
- Defined: adds outputs stat_rd_cnt[15:0] and stat_wr_cnt[15:0], saturating counters incremented in DONE per direction. Also adds input stat_clr, which synchronously zeroes both counters; stat_clr has priority over an increment in the same cycle. All three reset to 0.
- Undefined: the ports and logic are absent and the rest of the behaviour is identical.

Decomposition:
- Shared package ppnx_pkg:
  - Mode localparams (PPNX_FULL, PPNX_UPPER, PPNX_LOWER, PPNX_UREST).
  - State encoding (IDLE/TURN/ACTIVE/DONE).
  - Direction constants DIR_TO_IDB = 1, DIR_TO_PPN = 0.
- Sub-module ppnx_rr_arb: 2-way round-robin arbiter. Inputs are the two requests, the enable, and the last owner; outputs are the grant and the owner.
- The FSM and the enable decode stay in ppnx_xfer_ctl.

Test Plan:
- Reset: hold sys_rst_n = 0, then release; expect enables = 1, ESTOF_n = 1, busy = 0. Then uc_req, wr = 0, mode = 00 at cycle 0 -> EIPU_n = EIPL_n = 0 over cycles 1-2, uc_ack at cycle 3, no TURN.
- Direction change: uc write mode 10 after a read -> ESTOF_n 1->0 in a cycle with EIPL_n = 1, then EIPL_n = 0 for 2 cycles, ack at cycle 4, EIPU_n stays 1 throughout.
- Contention: uc_req and mnt_req rise together, repeated 4 times -> grants alternate uc, mnt, uc, mnt; acks never overlap; gnt_mnt toggles.
- Restricted mode: mnt write mode 11 -> EIPUR_n = 0 exactly while EIPU_n = 0, EIPL_n = 1, mnt_ack at the end.
- Reset mid-operation: assert sys_rst_n in the second ACTIVE cycle -> enables = 1 immediately, no ack; after release, a pending request is re-granted normally.
- Stats (PPNX_XFER_STATS_EN): 3 reads + 2 writes -> stat_rd_cnt = 3, stat_wr_cnt = 2; stat_clr -> 0/0. Preload a counter at 16'hFFFF -> it stays at FFFF after the next transfer.

Source files
------------

// File: rtl/ppnx_pkg.sv
// Shared types and constants for the PPN<->IDB transfer controller.
// Mode codes, FSM states, direction values and enable decode.
package ppnx_pkg;

    localparam logic [1:0] PPNX_FULL  = 2'b00;
    localparam logic [1:0] PPNX_UPPER = 2'b01;
    localparam logic [1:0] PPNX_LOWER = 2'b10;
    localparam logic [1:0] PPNX_UREST = 2'b11;

    localparam logic DIR_TO_IDB = 1'b1;
    localparam logic DIR_TO_PPN = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        TURN   = 2'b01,
        ACTIVE = 2'b10,
        DONE   = 2'b11
    } xfer_state_t;

    // Returns {EIPU_n, EIPL_n, EIPUR_n} for an active transfer.
    function automatic logic [2:0] en_decode(input logic [1:0] mode);
        logic [2:0] en;
        en = 3'b111;
        unique case (mode)
            PPNX_FULL:  en = 3'b001;
            PPNX_UPPER: en = 3'b011;
            PPNX_LOWER: en = 3'b101;
            PPNX_UREST: en = 3'b010;
            default:    en = 3'b111;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/ppnx_rr_arb.sv
// Two-way round-robin arbiter between the microcode and maintenance requesters.
// On contention the requester that did not own the last grant wins.
module ppnx_rr_arb
    import ppnx_pkg::*;
(
    input  logic req_uc,
    input  logic req_mnt,
    input  logic en,
    input  logic last_mnt,
    output logic gnt,
    output logic owner_mnt
);

    always_comb begin
        gnt       = en & (req_uc | req_mnt);
        owner_mnt = (req_uc & req_mnt) ? ~last_mnt : req_mnt;
    end

endmodule

// File: rtl/ppnx_xfer_ctl.sv
// PPN<->IDB transceiver sequencer: arbitration, turnaround and enable timing.
// Optional transfer counters are built when PPNX_XFER_STATS_EN is defined.
module ppnx_xfer_ctl
    import ppnx_pkg::*;
#(
    parameter int HOLD_CYC = 2,
    parameter int TURN_CYC = 1
) (
    input  logic       sysclk,
    input  logic       sys_rst_n,
    input  logic       uc_req,
    input  logic       uc_wr,
    input  logic [1:0] uc_mode,
    output logic       uc_ack,
    input  logic       mnt_req,
    input  logic       mnt_wr,
    input  logic [1:0] mnt_mode,
    output logic       mnt_ack,
    output logic       EIPU_n,
    output logic       EIPL_n,
    output logic       EIPUR_n,
    output logic       ESTOF_n,
    output logic       busy,
    output logic       gnt_mnt
`ifdef PPNX_XFER_STATS_EN
    ,
    input  logic        stat_clr,
    output logic [15:0] stat_rd_cnt,
    output logic [15:0] stat_wr_cnt
`endif
);

    localparam logic [3:0] HOLD_M1 = 4'(HOLD_CYC - 1);
    localparam logic [3:0] TURN_M1 = 4'(TURN_CYC - 1);

    xfer_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  mode_q, mode_d;
    logic [2:0]  en_d;
    logic        estof_d, busy_d, gnt_mnt_d;
    logic        uc_ack_d, mnt_ack_d;
    logic        sel_wr;
    logic        arb_gnt, arb_mnt;

    ppnx_rr_arb u_arb (
        .req_uc    (uc_req),
        .req_mnt   (mnt_req),
        .en        (state_q == IDLE),
        .last_mnt  (gnt_mnt),
        .gnt       (arb_gnt),
        .owner_mnt (arb_mnt)
    );

    // Outputs are registered from next-state values so enables move on the grant edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        en_d      = 3'b111;
        estof_d   = ESTOF_n;
        busy_d    = busy;
        gnt_mnt_d = gnt_mnt;
        uc_ack_d  = 1'b0;
        mnt_ack_d = 1'b0;
        sel_wr    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_gnt) begin
                    gnt_mnt_d = arb_mnt;
                    sel_wr    = arb_mnt ? mnt_wr : uc_wr;
                    mode_d    = arb_mnt ? mnt_mode : uc_mode;
                    busy_d    = 1'b1;
                    estof_d   = sel_wr ? DIR_TO_PPN : DIR_TO_IDB;
                    if (estof_d != ESTOF_n) begin
                        state_d = TURN;
                        cnt_d   = TURN_M1;
                    end else begin
                        state_d = ACTIVE;
                        cnt_d   = HOLD_M1;
                        en_d    = en_decode(mode_d);
                    end
                end
            end
            TURN: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACTIVE;
                    cnt_d   = HOLD_M1;
                    en_d    = en_decode(mode_q);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACTIVE: begin
                if (cnt_q == 4'd0) begin
                    state_d   = DONE;
                    uc_ack_d  = ~gnt_mnt;
                    mnt_ack_d = gnt_mnt;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    en_d  = en_decode(mode_q);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            mode_q  <= PPNX_FULL;
            EIPU_n  <= 1'b1;
            EIPL_n  <= 1'b1;
            EIPUR_n <= 1'b1;
            ESTOF_n <= DIR_TO_IDB;
            busy    <= 1'b0;
            gnt_mnt <= 1'b1;
            uc_ack  <= 1'b0;
            mnt_ack <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            EIPU_n  <= en_d[2];
            EIPL_n  <= en_d[1];
            EIPUR_n <= en_d[0];
            ESTOF_n <= estof_d;
            busy    <= busy_d;
            gnt_mnt <= gnt_mnt_d;
            uc_ack  <= uc_ack_d;
            mnt_ack <= mnt_ack_d;
        end
    end

`ifdef PPNX_XFER_STATS_EN
    logic [15:0] stat_rd_q, stat_wr_q;

    // ESTOF_n still holds the finished transfer's direction during DONE.
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stat_rd_q <= 16'd0;
            stat_wr_q <= 16'd0;
        end else if (stat_clr) begin
            stat_rd_q <= 16'd0;
            stat_wr_q <= 16'd0;
        end else if (state_q == DONE) begin
            if (ESTOF_n == DIR_TO_PPN) begin
                if (stat_wr_q != 16'hFFFF) stat_wr_q <= stat_wr_q + 16'd1;
            end else begin
                if (stat_rd_q != 16'hFFFF) stat_rd_q <= stat_rd_q + 16'd1;
            end
        end
    end

    assign stat_rd_cnt = stat_rd_q;
    assign stat_wr_cnt = stat_wr_q;
`endif

endmodule
